// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises din, votes each bit 2-of-3 around mid-bit,
// and assembles start/data/parity/stop into a word with one-cycle valid and error flags.
module uart_rx_framer #(
  parameter int SAMPLE_RATIO = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sample_clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 sample_sig,
  output logic                 busy
);

  localparam int H  = SAMPLE_RATIO / 2;
  localparam int TW = $clog2(SAMPLE_RATIO);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_LO      = TW'(H - 1);
  localparam logic [TW-1:0] T_MID     = TW'(H);
  localparam logic [TW-1:0] T_HI      = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(SAMPLE_RATIO - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_t;

  state_t state, state_next;

  logic                 sync1, s, s_prev;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic                 v_lo, v_mid;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, stop_bad;

  logic fall, decide, vote, last_data, last_stop, par_calc, par_err_now;

  always_comb begin
    fall        = s_prev & ~s;
    decide      = (tick == T_HI);
    vote        = (v_lo & v_mid) | (v_lo & s) | (v_mid & s);
    last_data   = (bit_cnt == DATA_LAST);
    last_stop   = (bit_cnt == STOP_LAST);
    par_calc    = (^shreg) ^ vote;
    // odd parity wants an odd count of ones over data+parity, even wants an even count
    par_err_now = (PARITY == 1) ? ~par_calc : par_calc;
  end

  // Next-state logic; the stop decision returns to idle at mid-bit so a
  // back-to-back start edge is not missed.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (fall) state_next = ST_START;
      ST_START: if (decide) state_next = vote ? ST_IDLE : ST_DATA;
      ST_DATA:  if (decide && last_data) state_next = (PARITY != 0) ? ST_PAR : ST_STOP;
      ST_PAR:   if (decide) state_next = ST_STOP;
      ST_STOP:  if (decide && last_stop) state_next = vote ? ST_IDLE : ST_BRK;
      ST_BRK:   if (s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      s          <= 1'b1;
      s_prev     <= 1'b1;
      state      <= ST_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      v_lo       <= 1'b0;
      v_mid      <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      sample_sig <= 1'b0;
    end else begin
      sync1      <= din;
      s          <= sync1;
      s_prev     <= s;
      state      <= state_next;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      sample_sig <= 1'b0;

      // the edge cycle itself is tick 0, so the first counted cycle is tick 1
      if (state == ST_IDLE) tick <= fall ? TW'(1) : '0;
      else if (tick == T_LAST) tick <= '0;
      else tick <= tick + 1'b1;

      if (tick == T_LO)  v_lo  <= s;
      if (tick == T_MID) v_mid <= s;

      if (decide) begin
        unique case (state)
          ST_START: begin
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
          ST_DATA: begin
            shreg      <= {vote, shreg[DATA_BITS-1:1]};
            sample_sig <= 1'b1;
            bit_cnt    <= last_data ? '0 : bit_cnt + 1'b1;
          end
          ST_PAR: par_bad <= par_err_now;
          ST_STOP: begin
            if (last_stop) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
              parity_err <= par_bad;
              frame_err  <= stop_bad | ~vote;
              bit_cnt    <= '0;
            end else begin
              stop_bad <= stop_bad | ~vote;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
